// File: rtl/three_motor_ctrl_pkg.sv
// Shared constants for the three-motor controller: register map, drive-mode
// encodings and small decode helpers used by the top and the channels.
package three_motor_ctrl_pkg;

    localparam logic [9:0] ADDR_TARGET1 = 10'd1;
    localparam logic [9:0] ADDR_TARGET2 = 10'd2;
    localparam logic [9:0] ADDR_TARGET3 = 10'd3;
    localparam logic [9:0] ADDR_CTRL    = 10'd4;
    localparam logic [9:0] ADDR_CFG     = 10'd5;
    localparam logic [9:0] ADDR_PERIOD  = 10'd6;
    localparam logic [9:0] ADDR_DEC     = 10'd7;
    localparam logic [9:0] ADDR_TABLE   = 10'd512;

    typedef enum logic [1:0] {
        MODE_STOP  = 2'b00,
        MODE_FWD   = 2'b01,
        MODE_REV   = 2'b10,
        MODE_BRAKE = 2'b11
    } mode_e;

    // Encoder pins carry {b1, b1^b0}; undo the Gray coding.
    function automatic logic [1:0] gray2bin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    // Saturate a signed position error into the 5-bit table index field.
    function automatic logic [4:0] clip_err(input logic signed [31:0] e);
        if (e < -32'sd16)
            return 5'b10000;
        else if (e > 32'sd15)
            return 5'b01111;
        else
            return e[4:0];
    endfunction

endpackage

// File: rtl/three_motor_ctrl_motor_channel.sv
// One motor: encoder sync/deglitch/decode, position and slowness estimate,
// table index generation, dead-time tracking and PWM compare.
module motor_channel
    import three_motor_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_enc,
    input  logic [3:0]  i_deg_div,
    input  logic [3:0]  i_dec,
    input  logic        i_tick,
    input  logic        i_clr_pos,
    input  logic        i_clr_per,
    input  logic [31:0] i_target,
    input  logic        i_ld,
    input  logic [1:0]  i_ent_mode,
    input  logic [7:0]  i_ent_duty,
    input  logic [3:0]  i_pwm_delay,
    input  logic [7:0]  i_pwm_cnt,
    input  logic        i_en,
    output logic [31:0] o_pos,
    output logic        o_flag,
    output logic [8:0]  o_idx,
    output logic [1:0]  o_mot
);

    logic [1:0]  r_s1, r_s2, r_cand, r_stab;
    logic [4:0]  r_run;
    logic [31:0] r_pos;
    logic        r_flag;
    logic [3:0]  r_per;
    mode_e       r_mode;
    logic [7:0]  r_duty;
    logic [3:0]  r_dead;
    logic [1:0]  r_mot;

    logic [4:0]         w_run;
    logic               w_acc, w_inc, w_dec, w_ill;
    logic [1:0]         w_delta;
    logic [3:0]         w_per_dec, w_per_nxt;
    logic signed [31:0] w_err;
    logic               w_flip;

    // w_run is the length of the current constant run on the synced pins,
    // including this cycle; a differing value is accepted once the run
    // exceeds deglitch_div.
    assign w_run   = (r_s2 == r_cand) ? r_run + 5'd1 : 5'd1;
    assign w_acc   = (r_s2 != r_stab) && (w_run > {1'b0, i_deg_div});
    assign w_delta = gray2bin(r_s2) - gray2bin(r_stab);
    assign w_inc   = w_acc && (w_delta == 2'd1);
    assign w_dec   = w_acc && (w_delta == 2'd3);
    assign w_ill   = w_acc && (w_delta == 2'd2);

    // Step first, then tick, both saturating.
    assign w_per_dec = (w_inc || w_dec) ? ((r_per > i_dec) ? r_per - i_dec : 4'd0) : r_per;
    assign w_per_nxt = (i_tick && w_per_dec != 4'd15) ? w_per_dec + 4'd1 : w_per_dec;

    assign w_err  = i_target - r_pos;
    assign w_flip = (i_ent_mode == MODE_FWD && r_mode == MODE_REV) ||
                    (i_ent_mode == MODE_REV && r_mode == MODE_FWD);

    // Two-flop synchronizer and deglitch filter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1   <= 2'b00;
            r_s2   <= 2'b00;
            r_cand <= 2'b00;
            r_stab <= 2'b00;
            r_run  <= 5'd0;
        end else begin
            r_s1   <= i_enc;
            r_s2   <= r_s1;
            r_cand <= r_s2;
            r_run  <= (r_s2 == r_stab || w_acc) ? 5'd0 : w_run;
            if (w_acc)
                r_stab <= r_s2;
        end
    end

    // Position counter and sticky illegal-jump flag; clear beats a step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos  <= 32'd0;
            r_flag <= 1'b0;
        end else if (i_clr_pos) begin
            r_pos  <= 32'd0;
            r_flag <= 1'b0;
        end else begin
            if (w_inc)
                r_pos <= r_pos + 32'd1;
            else if (w_dec)
                r_pos <= r_pos - 32'd1;
            if (w_ill)
                r_flag <= 1'b1;
        end
    end

    // Slowness estimate: grows with time, shrinks on each encoder step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_per <= 4'd0;
        else if (i_clr_per)
            r_per <= 4'd0;
        else
            r_per <= w_per_nxt;
    end

    // Latch new drive code per period, arm dead time on a direction flip,
    // and generate the registered PWM output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode <= MODE_STOP;
            r_duty <= 8'd0;
            r_dead <= 4'd0;
            r_mot  <= MODE_STOP;
        end else if (i_clr_per) begin
            r_mode <= MODE_STOP;
            r_duty <= 8'd0;
            r_dead <= 4'd0;
            r_mot  <= MODE_STOP;
        end else begin
            if (i_ld) begin
                r_mode <= mode_e'(i_ent_mode);
                r_duty <= i_ent_duty;
                if (w_flip)
                    r_dead <= i_pwm_delay;
                else if (r_dead != 4'd0)
                    r_dead <= r_dead - 4'd1;
            end
            r_mot <= (i_en && r_dead == 4'd0 && i_pwm_cnt < r_duty) ? r_mode : MODE_STOP;
        end
    end

    assign o_pos  = r_pos;
    assign o_flag = r_flag;
    assign o_idx  = {clip_err(w_err), r_per};
    assign o_mot  = r_mot;

endmodule

// File: rtl/three_motor_ctrl.sv
// Three-motor closed-loop controller: register bus, shared drive table,
// PWM counter and period prescaler, plus three motor channels.
module three_motor_ctrl
    import three_motor_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_we,
    input  logic        i_wa,
    input  logic [15:0] i_di,
    output logic [31:0] o_dout,
    input  logic [1:0]  i_encod1,
    input  logic [1:0]  i_encod2,
    input  logic [1:0]  i_encod3,
    output logic [1:0]  o_mot1,
    output logic [1:0]  o_mot2,
    output logic [1:0]  o_mot3
);

    logic [9:0]       r_addr;
    logic             r_pend;
    logic [15:0]      r_lo;
    logic [2:0][31:0] r_tgt;
    logic             r_en;
    logic [7:0]       r_pwm_cycle;
    logic [3:0]       r_pwm_delay, r_deg, r_dec;
    logic [15:0]      r_epc, r_pre;
    logic [7:0]       r_cnt;
    logic [2:0][9:0]  r_ent;
    logic [31:0]      r_dout;
    logic [31:0]      r_tab [512];

    logic [31:0]      w_word, w_rd;
    logic             w_clr_pos, w_clr_per, w_tick, w_ld;
    logic [8:0]       w_lk_idx;
    logic [2:0][1:0]  w_enc, w_mot;
    logic [2:0][31:0] w_pos;
    logic [2:0][8:0]  w_idx;
    logic [2:0]       w_flag;

    // A data write commits one cycle after its strobe, with the high half on di.
    assign w_word    = {i_di, r_lo};
    assign w_clr_pos = r_pend && (r_addr == ADDR_CTRL) && w_word[1];
    assign w_clr_per = r_pend && (r_addr == ADDR_CTRL) && w_word[2];
    assign w_tick    = (r_pre >= r_epc);
    assign w_ld      = (r_cnt == 8'd3);
    assign w_lk_idx  = (r_cnt == 8'd1) ? w_idx[1] : (r_cnt == 8'd2) ? w_idx[2] : w_idx[0];
    assign w_enc     = {i_encod3, i_encod2, i_encod1};

    // Bus capture, address pointer and register commit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr      <= 10'd0;
            r_pend      <= 1'b0;
            r_lo        <= 16'd0;
            r_tgt       <= '0;
            r_en        <= 1'b0;
            r_pwm_cycle <= 8'd0;
            r_pwm_delay <= 4'd0;
            r_deg       <= 4'd0;
            r_epc       <= 16'd0;
            r_dec       <= 4'd0;
        end else begin
            r_pend <= i_we && !i_wa;
            if (i_we && !i_wa)
                r_lo <= i_di;
            if (r_pend)
                r_addr <= r_addr + 10'd1;
            else if (i_we && i_wa)
                r_addr <= i_di[9:0];
            if (r_pend) begin
                case (r_addr)
                    ADDR_TARGET1: r_tgt[0] <= w_word;
                    ADDR_TARGET2: r_tgt[1] <= w_word;
                    ADDR_TARGET3: r_tgt[2] <= w_word;
                    ADDR_CTRL:    r_en     <= w_word[0];
                    ADDR_CFG:     {r_deg, r_pwm_delay, r_pwm_cycle} <= w_word[15:0];
                    ADDR_PERIOD:  r_epc    <= w_word[15:0];
                    ADDR_DEC:     r_dec    <= w_word[3:0];
                    default: ;
                endcase
            end
        end
    end

    // Drive table storage; contents are undefined until software loads them.
    always_ff @(posedge i_clk) begin
        if (r_pend && r_addr >= ADDR_TABLE)
            r_tab[r_addr[8:0]] <= w_word;
    end

    // Readback mux for the current address.
    always_comb begin
        w_rd = 32'd0;
        if (r_addr >= ADDR_TABLE)
            w_rd = r_tab[r_addr[8:0]];
        else begin
            case (r_addr)
                ADDR_TARGET1: w_rd = w_pos[0];
                ADDR_TARGET2: w_rd = w_pos[1];
                ADDR_TARGET3: w_rd = w_pos[2];
                ADDR_CTRL:    w_rd = {25'd0, w_flag, 3'd0, r_en};
                ADDR_CFG:     w_rd = {16'd0, r_deg, r_pwm_delay, r_pwm_cycle};
                ADDR_PERIOD:  w_rd = {16'd0, r_epc};
                ADDR_DEC:     w_rd = {28'd0, r_dec};
                default:      w_rd = 32'd0;
            endcase
        end
    end

    // Registered readback, PWM counter, period prescaler and per-motor
    // table fetch (motor 1, 2, 3 in counter cycles 0, 1, 2).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dout <= 32'd0;
            r_cnt  <= 8'd0;
            r_pre  <= 16'd0;
            r_ent  <= '0;
        end else begin
            r_dout <= w_rd;
            r_cnt  <= (r_cnt >= r_pwm_cycle) ? 8'd0 : r_cnt + 8'd1;
            r_pre  <= w_tick ? 16'd0 : r_pre + 16'd1;
            case (r_cnt)
                8'd0: r_ent[0] <= r_tab[w_lk_idx][9:0];
                8'd1: r_ent[1] <= r_tab[w_lk_idx][9:0];
                8'd2: r_ent[2] <= r_tab[w_lk_idx][9:0];
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_ch
        motor_channel u_ch (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_enc       (w_enc[g]),
            .i_deg_div   (r_deg),
            .i_dec       (r_dec),
            .i_tick      (w_tick),
            .i_clr_pos   (w_clr_pos),
            .i_clr_per   (w_clr_per),
            .i_target    (r_tgt[g]),
            .i_ld        (w_ld),
            .i_ent_mode  (r_ent[g][9:8]),
            .i_ent_duty  (r_ent[g][7:0]),
            .i_pwm_delay (r_pwm_delay),
            .i_pwm_cnt   (r_cnt),
            .i_en        (r_en),
            .o_pos       (w_pos[g]),
            .o_flag      (w_flag[g]),
            .o_idx       (w_idx[g]),
            .o_mot       (w_mot[g])
        );
    end

    assign o_dout = r_dout;
    assign o_mot1 = w_mot[0];
    assign o_mot2 = w_mot[1];
    assign o_mot3 = w_mot[2];

endmodule

// File: tb/tb_three_motor_ctrl.sv
// Directed bench for three_motor_ctrl: register vectors from a table, then
// hand-written encoder, PWM, dead-time and slowness sequences.
module tb_three_motor_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0, wa = 1'b0;
    logic [15:0] di = 16'd0;
    logic [31:0] dout;
    logic [1:0]  e1 = 2'b00, e2 = 2'b00, e3 = 2'b00;
    logic [1:0]  m1, m2, m3;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          wr;
        logic [9:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [18];

    always #5 clk = ~clk;

    three_motor_ctrl dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_we     (we),
        .i_wa     (wa),
        .i_di     (di),
        .o_dout   (dout),
        .i_encod1 (e1),
        .i_encod2 (e2),
        .i_encod3 (e3),
        .o_mot1   (m1),
        .o_mot2   (m2),
        .o_mot3   (m3)
    );

    function automatic vec_t mk(input bit wr, input logic [9:0] a,
                                input logic [31:0] d, input logic [31:0] exp);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_addr(input logic [9:0] a);
        @(negedge clk); we = 1'b1; wa = 1'b1; di = {6'd0, a};
        @(negedge clk); we = 1'b0; wa = 1'b0; di = 16'd0;
    endtask

    task automatic bus_wr(input logic [31:0] d);
        @(negedge clk); we = 1'b1; wa = 1'b0; di = d[15:0];
        @(negedge clk); we = 1'b0; di = d[31:16];
        @(negedge clk); di = 16'd0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        bus_addr(a);
        bus_wr(d);
    endtask

    task automatic rd(input logic [9:0] a, output logic [31:0] v);
        bus_addr(a);
        @(negedge clk);
        v = dout;
    endtask

    // Cycles until mot1 shows v; gives up at 400.
    task automatic wait_m1(input logic [1:0] v, output int n);
        n = 0;
        while (m1 !== v && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic [31:0] v;
        int n, c, last10;
        bit found;

        vt[0]  = mk(0, 10'd1,   32'd0,          32'd0);
        vt[1]  = mk(0, 10'd2,   32'd0,          32'd0);
        vt[2]  = mk(0, 10'd3,   32'd0,          32'd0);
        vt[3]  = mk(0, 10'd4,   32'd0,          32'd0);
        vt[4]  = mk(0, 10'd5,   32'd0,          32'd0);
        vt[5]  = mk(0, 10'd6,   32'd0,          32'd0);
        vt[6]  = mk(0, 10'd7,   32'd0,          32'd0);
        vt[7]  = mk(0, 10'd0,   32'd0,          32'd0);
        vt[8]  = mk(1, 10'd6,   32'h1234_00A5,  32'h0000_00A5);
        vt[9]  = mk(1, 10'd7,   32'hFFFF_FFF6,  32'h0000_0006);
        vt[10] = mk(1, 10'd5,   32'hBEEF_A5C3,  32'h0000_A5C3);
        vt[11] = mk(1, 10'd600, 32'hABCD_1234,  32'hABCD_1234);
        vt[12] = mk(1, 10'd300, 32'h5555_5555,  32'h0000_0000);
        vt[13] = mk(1, 10'd4,   32'h0000_00F1,  32'h0000_0001);
        vt[14] = mk(1, 10'd4,   32'h0000_0000,  32'h0000_0000);
        vt[15] = mk(1, 10'd6,   32'h0000_0000,  32'h0000_0000);
        vt[16] = mk(1, 10'd7,   32'h0000_0000,  32'h0000_0000);
        vt[17] = mk(1, 10'd5,   32'h0000_0000,  32'h0000_0000);

        // Reset
        cyc(3);
        chk("rst_dout", dout, 32'd0);
        chk("rst_mot", {26'd0, m1, m2, m3}, 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // Register vectors
        foreach (vt[i]) begin
            if (vt[i].wr)
                wr(vt[i].a, vt[i].d);
            rd(vt[i].a, v);
            chk($sformatf("vec%0d_addr%0d", i, vt[i].a), v, vt[i].exp);
        end

        // Address wrap 1023->0 and auto-increment through targets into ctrl/cfg
        bus_addr(10'd1023);
        bus_wr(32'hCAFE_0042);
        bus_wr(32'h1111_1111);
        bus_wr(32'hFFFF_FFCE);
        bus_wr(32'd10);
        bus_wr(32'd1);
        bus_wr(32'd0);
        bus_wr(32'h0000_7000);
        rd(10'd5, v);    chk("autoinc_cfg", v, 32'h0000_7000);
        rd(10'd1023, v); chk("wrap_tab1023", v, 32'hCAFE_0042);
        rd(10'd0, v);    chk("wrap_addr0", v, 32'd0);
        rd(10'd1, v);    chk("pos1_not_target", v, 32'd0);

        // Encoder latency with deglitch_div=7: 2 + 8 cycles to position
        @(negedge clk); e1 = 2'b01;
        cyc(10); chk("enc_lat_before", dout, 32'd0);
        cyc(1);  chk("enc_lat_after", dout, 32'd1);
        e1 = 2'b11; cyc(12);
        e1 = 2'b10; cyc(12);
        chk("enc_fwd3", dout, 32'd3);
        e1 = 2'b00; cyc(5);
        e1 = 2'b10; cyc(20);
        chk("enc_glitch", dout, 32'd3);
        e1 = 2'b00; cyc(12);
        chk("enc_fwd4", dout, 32'd4);
        e1 = 2'b11; cyc(12);
        chk("enc_illegal_pos", dout, 32'd4);
        rd(10'd4, v); chk("illegal_flag", v, 32'h0000_0010);
        wr(10'd4, 32'd2);
        rd(10'd1, v); chk("clr_pos", v, 32'd0);
        rd(10'd4, v); chk("clr_flag", v, 32'd0);
        e2 = 2'b10; cyc(12);
        rd(10'd2, v); chk("enc2_rev", v, 32'hFFFF_FFFF);
        rd(10'd3, v); chk("enc3_idle", v, 32'd0);

        // PWM: motor1 err=-16 per=15 -> mode 10 duty 0x20, cycle 0x44
        wr(10'd783, 32'h0000_0220);
        wr(10'd767, 32'h0000_0120);
        wr(10'd703, 32'h0000_02FF);
        wr(10'd543, 32'h0000_03FF);
        wr(10'd5,   32'h0000_7243);
        wr(10'd4,   32'd1);
        cyc(300);
        chk("mot2_const", {30'd0, m2}, 32'd2);
        chk("mot3_const", {30'd0, m3}, 32'd3);
        wait_m1(2'b00, n);
        wait_m1(2'b10, n);
        wait_m1(2'b00, n);
        chk("pwm_on_len", n, 32'h20);
        wait_m1(2'b10, n);
        chk("pwm_off_len", n, 32'h24);

        // Direction flip 10 -> 01 with pwm_delay=2: 2 full periods of 00
        wr(10'd1, 32'd100);
        c = 0; last10 = -1; found = 0;
        while (c < 600 && !found) begin
            if (m1 === 2'b10) last10 = c;
            if (m1 === 2'b01) found = 1;
            else begin
                @(negedge clk);
                c++;
            end
        end
        chk("flip_seen", {31'd0, found}, 32'd1);
        chk("dead_gap", c - last10 - 1, 32'd136);

        // Disable forces all outputs off
        wr(10'd4, 32'd0);
        cyc(2);
        chk("disable_mot", {26'd0, m1, m2, m3}, 32'd0);

        // Slowness: dec_on_pulse=15 empties the estimate on a step, slow
        // prescaler keeps it at 0 -> index {err=-16, per=0}
        wr(10'd1, 32'hFFFF_FFCE);
        wr(10'd768, 32'h0000_03FF);
        wr(10'd6, 32'h0000_FFFF);
        wr(10'd7, 32'd15);
        e1 = 2'b10; cyc(12);
        rd(10'd1, v); chk("enc_step_pos", v, 32'd1);
        wr(10'd4, 32'd1);
        cyc(250);
        chk("slow_mode", {30'd0, m1}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
